bp_iteration_scheduler: RTL and testbench
=========================================

Name: bp_iteration_scheduler

Overview:
Control FSM that sequences the belief-propagation datapath through repeated row (check-node) and column (variable-node) phases. It adds a configurable iteration limit, early termination on zero syndrome, and a per-phase watchdog. It sits between the decoder top level (start/done handshake) and the BP datapath's row/column processing units and parity-check-matrix load controls. It replaces fixed-count sequencing with a status-reporting scheduler.

Parameters:
N_ROWS, 3, number of check rows; each row unit returns a done pulse
N_COLS, 6, number of variable columns; each column unit returns a done pulse
ITER_W, 4, width of iteration limit and counter
TIMEOUT_CYCLES, 256, maximum cycles allowed in one wait phase
TMO_W, 9, watchdog counter width; must satisfy 2**TMO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request decode; sampled only in IDLE
max_iterations  in  ITER_W  iteration limit, sampled at start; 0 treated as 1
row_done  in  N_ROWS  per-row completion pulses from datapath
col_done  in  N_COLS  per-column completion pulses from datapath
syndrome_zero  in  1  datapath hard-decision parity check; valid the cycle after load_sum_vector
initialize_parity_check_matrix  out  1  load channel LLRs into matrix
load_parity_check_matrix  out  1  matrix register write enable
select_input_to_parity_check_matrix  out  2  0=received vector, 1=row results, 2=column results
start_row_processing  out  1  one-cycle pulse launching all row units
start_column_processing  out  1  one-cycle pulse launching all column units
load_sum_vector  out  1  capture a-posteriori sum vector
iteration_count  out  ITER_W  completed iterations
busy  out  1  high from INIT to DONE inclusive
done  out  1  one-cycle completion pulse
converged  out  1  status: syndrome zero at exit; held until next start
timeout_error  out  1  status: watchdog fired; held until next start

Behaviour:
- Reset (sync): state=IDLE; all outputs 0; sticky flags, watchdog, iteration_count, latched limit cleared. Reset mid-decode aborts immediately; no done pulse.
- Outputs are Moore-decoded from state. Outputs not listed for a state are 0.
- IDLE: start=1 -> INIT; latch max(max_iterations,1); clear converged, timeout_error, iteration_count.
- INIT (1 cycle): initialize_parity_check_matrix=1, load_parity_check_matrix=1, select=0 -> ROW_START.
- ROW_START (1 cycle): start_row_processing=1; clear row sticky flags; clear watchdog -> ROW_WAIT.
- ROW_WAIT: sticky |= row_done each cycle; watchdog++. Exit when (sticky|row_done) is all ones -> ROW_LOAD. If watchdog reaches TIMEOUT_CYCLES first -> DONE with timeout_error=1.
- ROW_LOAD (1 cycle): load_parity_check_matrix=1, select=1 -> COL_START.
- COL_START / COL_WAIT / COL_LOAD: mirror the row phase with col_done. COL_LOAD uses select=2, then goes to SUM_LOAD.
- SUM_LOAD (1 cycle): load_sum_vector=1; iteration_count++ -> CHECK.
- CHECK (1 cycle): sample syndrome_zero.
  - If syndrome_zero=1: converged=1 -> DONE.
  - Else if iteration_count == latched limit: -> DONE with converged=0.
  - Else: -> ROW_START.
- DONE (1 cycle): done=1, busy=1 -> IDLE. Status outputs and iteration_count hold until the next accepted start.
- Done pulses seen outside the matching WAIT state are ignored. Duplicate pulses within one phase are harmless.
- Simultaneous last done pulse and watchdog expiry: completion wins.
- start while busy: ignored. start in the DONE cycle: ignored. start must be reasserted in IDLE.
- Minimum iteration is 8 cycles when all done pulses arrive on the first WAIT cycle.
- Minimum start-to-done latency is 1 + 1 + 8 + 1: start sampled, INIT, one iteration, DONE.
- Counter wrap is impossible: exit occurs at the limit, and the limit is at most 2**ITER_W-1.

Decomposition:
- Shared package bp_pkg holds:
  - state enum (IDLE, INIT, ROW_START, ROW_WAIT, ROW_LOAD, COL_START, COL_WAIT, COL_LOAD, SUM_LOAD, CHECK, DONE);
  - select encodings SEL_RECEIVED=0, SEL_ROW=1, SEL_COL=2;
  - default N_ROWS and N_COLS.
- One natural sub-module, bp_phase_tracker, is instantiated twice (row and column phases). Parameter: width. It provides clear, the sticky OR, an all-done flag, the watchdog counter, and a timeout flag.

Test Plan:
- Nominal convergence: max_iterations=4; row_done/col_done all asserted 2 cycles after each start pulse; syndrome_zero=1 after iteration 2 -> done pulse, converged=1, iteration_count=2, timeout_error=0.
- Iteration limit: max_iterations=3, syndrome_zero held 0 -> exactly 3 start_row_processing and 3 load_sum_vector pulses, then done with converged=0 and iteration_count=3. With max_iterations=0 -> exactly 1 iteration.
- Staggered dones: row_done bits arrive in cycles 1, 5 and 9 of ROW_WAIT; stray col_done pulses during the row phase -> ROW_LOAD only after bit 2. The stray pulses do not shorten COL_WAIT.
- Watchdog: col_done[5] never asserted -> done exactly TIMEOUT_CYCLES cycles into COL_WAIT; timeout_error=1, converged=0. The last row_done coinciding with expiry -> proceeds normally.
- Reset mid-decode: assert reset during COL_WAIT of iteration 2 -> next cycle all outputs 0, state IDLE, no done pulse. A following start runs a full decode from iteration_count=0.
- Handshake: start held high for 20 cycles across a whole decode -> exactly one decode per start accepted in IDLE; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/bp_iteration_scheduler_pkg.sv
// Shared definitions for the belief-propagation iteration scheduler.
// Contents:
//   state_t        - scheduler FSM states
//   SEL_*          - encodings for select_input_to_parity_check_matrix
//   DEFAULT_N_*    - default row/column unit counts
package bp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    ROW_START,
    ROW_WAIT,
    ROW_LOAD,
    COL_START,
    COL_WAIT,
    COL_LOAD,
    SUM_LOAD,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] SEL_RECEIVED = 2'd0;
  localparam logic [1:0] SEL_ROW      = 2'd1;
  localparam logic [1:0] SEL_COL      = 2'd2;

  localparam int DEFAULT_N_ROWS = 3;
  localparam int DEFAULT_N_COLS = 6;

endpackage

// File: rtl/bp_iteration_scheduler_if.sv
// Handshake/control bundle between the decoder top level, the BP datapath
// and the iteration scheduler.
// Signals:
//   start, max_iterations           - decode request and iteration limit
//   row_done, col_done              - per-unit completion pulses
//   syndrome_zero                   - datapath parity check result
//   initialize/load/select matrix   - parity-check-matrix load controls
//   start_row/column_processing     - phase launch pulses
//   load_sum_vector                 - a-posteriori sum capture
//   iteration_count, busy, done,
//   converged, timeout_error        - scheduler status
// Modports: master = decoder top level / datapath side, slave = scheduler.
interface bp_iteration_scheduler_if #(
  parameter int N_ROWS = 3,
  parameter int N_COLS = 6,
  parameter int ITER_W = 4
);

  logic                start;
  logic [ITER_W-1:0]   max_iterations;
  logic [N_ROWS-1:0]   row_done;
  logic [N_COLS-1:0]   col_done;
  logic                syndrome_zero;
  logic                initialize_parity_check_matrix;
  logic                load_parity_check_matrix;
  logic [1:0]          select_input_to_parity_check_matrix;
  logic                start_row_processing;
  logic                start_column_processing;
  logic                load_sum_vector;
  logic [ITER_W-1:0]   iteration_count;
  logic                busy;
  logic                done;
  logic                converged;
  logic                timeout_error;

  modport master (
    output start, max_iterations, row_done, col_done, syndrome_zero,
    input  initialize_parity_check_matrix, load_parity_check_matrix,
           select_input_to_parity_check_matrix, start_row_processing,
           start_column_processing, load_sum_vector, iteration_count,
           busy, done, converged, timeout_error
  );

  modport slave (
    input  start, max_iterations, row_done, col_done, syndrome_zero,
    output initialize_parity_check_matrix, load_parity_check_matrix,
           select_input_to_parity_check_matrix, start_row_processing,
           start_column_processing, load_sum_vector, iteration_count,
           busy, done, converged, timeout_error
  );

endinterface

// File: rtl/bp_iteration_scheduler_phase_tracker.sv
// bp_phase_tracker: completion and watchdog tracking for one processing
// phase (used once for rows, once for columns).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - restart the phase (sticky flags and watchdog to zero)
//   enable     - phase is waiting; accumulate pulses and count cycles
//   pulses     - per-unit completion pulses
//   all_done   - every unit has reported, including this cycle's pulses
//   timeout    - this is the last permitted wait cycle
module bp_phase_tracker #(
  parameter int WIDTH          = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] pulses,
  output logic             all_done,
  output logic             timeout
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] flags;
  logic [TMO_W-1:0] watchdog;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      flags    <= '0;
      watchdog <= '0;
    end else if (enable) begin
      flags    <= flags | pulses;
      watchdog <= watchdog + TMO_W'(1);
    end
  end

  // Including the live pulses lets a phase end in the cycle its last unit
  // reports; the FSM checks all_done before timeout so completion wins.
  assign all_done = &(flags | pulses);
  assign timeout  = enable && (watchdog == TMO_LAST);

endmodule

// File: rtl/bp_iteration_scheduler.sv
// bp_iteration_scheduler: sequences the BP datapath through alternating
// row (check-node) and column (variable-node) phases, with an iteration
// limit, early exit on zero syndrome and a per-phase watchdog.
// Ports:
//   clk    - clock, all logic on the rising edge
//   reset  - synchronous active-high reset; aborts any decode silently
//   bus    - slave side of bp_iteration_scheduler_if (handshake, datapath
//            controls, status)
import bp_pkg::*;

module bp_iteration_scheduler #(
  parameter int N_ROWS         = DEFAULT_N_ROWS,
  parameter int N_COLS         = DEFAULT_N_COLS,
  parameter int ITER_W         = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TMO_W          = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  bp_iteration_scheduler_if.slave  bus
);

  state_t            state, state_nxt;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W-1:0] iter_limit;
  logic              converged_q;
  logic              timeout_q;

  logic              accept, iter_inc, set_conv, set_tmo;
  logic              init_o, load_o, row_start_o, col_start_o, sum_o;
  logic              busy_o, done_o;
  logic [1:0]        sel_o;

  logic              row_clear, row_en, row_all, row_tmo;
  logic              col_clear, col_en, col_all, col_tmo;

  bp_phase_tracker #(
    .WIDTH(N_ROWS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(TMO_W)
  ) u_row_tracker (
    .clk(clk), .rst(reset), .clear(row_clear), .enable(row_en),
    .pulses(bus.row_done), .all_done(row_all), .timeout(row_tmo)
  );

  bp_phase_tracker #(
    .WIDTH(N_COLS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(TMO_W)
  ) u_col_tracker (
    .clk(clk), .rst(reset), .clear(col_clear), .enable(col_en),
    .pulses(bus.col_done), .all_done(col_all), .timeout(col_tmo)
  );

  assign row_clear = (state == ROW_START);
  assign row_en    = (state == ROW_WAIT);
  assign col_clear = (state == COL_START);
  assign col_en    = (state == COL_WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    iter_inc    = 1'b0;
    set_conv    = 1'b0;
    set_tmo     = 1'b0;
    init_o      = 1'b0;
    load_o      = 1'b0;
    sel_o       = SEL_RECEIVED;
    row_start_o = 1'b0;
    col_start_o = 1'b0;
    sum_o       = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        init_o    = 1'b1;
        load_o    = 1'b1;
        sel_o     = SEL_RECEIVED;
        state_nxt = ROW_START;
      end
      ROW_START: begin
        row_start_o = 1'b1;
        state_nxt   = ROW_WAIT;
      end
      ROW_WAIT: begin
        if (row_all) begin
          state_nxt = ROW_LOAD;
        end else if (row_tmo) begin
          set_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end
      ROW_LOAD: begin
        load_o    = 1'b1;
        sel_o     = SEL_ROW;
        state_nxt = COL_START;
      end
      COL_START: begin
        col_start_o = 1'b1;
        state_nxt   = COL_WAIT;
      end
      COL_WAIT: begin
        if (col_all) begin
          state_nxt = COL_LOAD;
        end else if (col_tmo) begin
          set_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end
      COL_LOAD: begin
        load_o    = 1'b1;
        sel_o     = SEL_COL;
        state_nxt = SUM_LOAD;
      end
      SUM_LOAD: begin
        sum_o     = 1'b1;
        iter_inc  = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        // iter_cnt already includes the iteration that just finished
        if (bus.syndrome_zero) begin
          set_conv  = 1'b1;
          state_nxt = DONE;
        end else if (iter_cnt == iter_limit) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ROW_START;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy_o    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Status registers: cleared on an accepted start, held through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_cnt    <= '0;
      iter_limit  <= '0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (accept) begin
      iter_cnt    <= '0;
      iter_limit  <= (bus.max_iterations == '0) ? ITER_W'(1) : bus.max_iterations;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (iter_inc) iter_cnt    <= iter_cnt + ITER_W'(1);
      if (set_conv) converged_q <= 1'b1;
      if (set_tmo)  timeout_q   <= 1'b1;
    end
  end

  assign bus.initialize_parity_check_matrix      = init_o;
  assign bus.load_parity_check_matrix            = load_o;
  assign bus.select_input_to_parity_check_matrix = sel_o;
  assign bus.start_row_processing                = row_start_o;
  assign bus.start_column_processing             = col_start_o;
  assign bus.load_sum_vector                     = sum_o;
  assign bus.iteration_count                     = iter_cnt;
  assign bus.busy                                = busy_o;
  assign bus.done                                = done_o;
  assign bus.converged                           = converged_q;
  assign bus.timeout_error                       = timeout_q;

endmodule

// File: tb/tb_bp_iteration_scheduler.sv
// Testbench for bp_iteration_scheduler: a cycle-level datapath responder
// drives done pulses and syndrome from per-iteration delay tables, and a
// latency/outcome model derived from the phase rules predicts each decode.
module tb_bp_iteration_scheduler;

  localparam int N_ROWS = 3;
  localparam int N_COLS = 6;
  localparam int ITER_W = 4;
  localparam int T      = 256;
  localparam int TMO_W  = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_iteration_scheduler_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .ITER_W(ITER_W)) bus();

  bp_iteration_scheduler #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .ITER_W(ITER_W),
    .TIMEOUT_CYCLES(T), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Per-iteration wait-cycle on which each unit reports (0 = never).
  int rd[16][N_ROWS];
  int cd[16][N_COLS];
  int conv_iter;
  bit stray_en;

  int cyc, n_rs, n_sl, n_done, done_cyc, sum_seen, row_cnt, col_cnt;
  bit row_act, col_act, chk_next;

  task automatic tb_clear();
    cyc = 0; n_rs = 0; n_sl = 0; n_done = 0; done_cyc = -1; sum_seen = 0;
    row_cnt = 0; col_cnt = 0; row_act = 0; col_act = 0; chk_next = 0;
  endtask

  task automatic set_delays(input int lo, input int hi);
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < N_ROWS; i++) rd[it][i] = $urandom_range(hi, lo);
      for (int i = 0; i < N_COLS; i++) cd[it][i] = $urandom_range(hi, lo);
    end
  endtask

  function automatic bit junk();
    return stray_en ? 1'($urandom_range(1, 0)) : 1'b0;
  endfunction

  // One clock: observe at the falling edge, then drive this cycle's inputs.
  task automatic step();
    logic [N_ROWS-1:0] rv;
    logic [N_COLS-1:0] cv;
    int idx;
    @(negedge clk);
    cyc++;
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.initialize_parity_check_matrix) sum_seen = 0;
    if (bus.start_row_processing) begin n_rs++; row_act = 1; row_cnt = 0; end
    else if (row_act && (bus.load_parity_check_matrix || bus.done || !bus.busy)) row_act = 0;
    else if (row_act) row_cnt++;
    if (bus.start_column_processing) begin col_act = 1; col_cnt = 0; end
    else if (col_act && (bus.load_parity_check_matrix || bus.done || !bus.busy)) col_act = 0;
    else if (col_act) col_cnt++;
    idx = sum_seen & 15;
    for (int i = 0; i < N_ROWS; i++)
      rv[i] = (row_act && row_cnt > 0) ? (rd[idx][i] == row_cnt) : junk();
    for (int i = 0; i < N_COLS; i++)
      cv[i] = (col_act && col_cnt > 0) ? (cd[idx][i] == col_cnt) : junk();
    bus.row_done = rv;
    bus.col_done = cv;
    bus.syndrome_zero = chk_next ? (conv_iter != 0 && sum_seen == conv_iter) : junk();
    chk_next = bus.load_sum_vector;
    if (bus.load_sum_vector) begin n_sl++; sum_seen++; end
  endtask

  function automatic int phase_max(input bit is_row, input int it0);
    int m = 0;
    int n = is_row ? N_ROWS : N_COLS;
    for (int i = 0; i < n; i++) begin
      int d = is_row ? rd[it0][i] : cd[it0][i];
      if (d == 0) return T + 1;
      if (d > m) m = d;
    end
    return m;
  endfunction

  // Edges from the accepting edge to DONE entry, plus final status.
  task automatic model(input int limit, output int lat, output int iters,
                       output bit conv, output bit tmo);
    int lm;
    lm = (limit == 0) ? 1 : limit;
    lat = 1; iters = 0; conv = 0; tmo = 0;
    for (int it = 1; it <= lm; it++) begin
      int rmax, cmax;
      rmax = phase_max(1, it - 1);
      cmax = phase_max(0, it - 1);
      if (rmax > T) begin lat += 1 + T; tmo = 1; break; end
      lat += 3 + rmax;
      if (cmax > T) begin lat += T; tmo = 1; break; end
      lat += cmax + 3;
      iters = it;
      if (it == conv_iter) begin conv = 1; break; end
    end
  endtask

  function automatic logic [14:0] out_vec();
    return {bus.initialize_parity_check_matrix, bus.load_parity_check_matrix,
            bus.select_input_to_parity_check_matrix, bus.start_row_processing,
            bus.start_column_processing, bus.load_sum_vector, bus.iteration_count,
            bus.busy, bus.done, bus.converged, bus.timeout_error};
  endfunction

  task automatic run_decode(input string name, input int limit, input bit noisy);
    int lat, iters, budget;
    bit conv, tmo;
    model(limit, lat, iters, conv, tmo);
    budget = lat + 20;
    tb_clear();
    bus.max_iterations = ITER_W'(limit);
    bus.start = 1'b1;
    step();
    bus.start = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
    tests++;
    if ({bus.busy, bus.initialize_parity_check_matrix, bus.load_parity_check_matrix,
         bus.select_input_to_parity_check_matrix} !== 5'b11100) begin
      fails++;
      $display("FAIL %s init_outputs: got %b expected 11100", name,
               {bus.busy, bus.initialize_parity_check_matrix, bus.load_parity_check_matrix,
                bus.select_input_to_parity_check_matrix});
    end
    while (n_done == 0 && cyc < budget) begin
      step();
      bus.start = (noisy && bus.busy) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    tests++;
    if (n_done == 0) begin
      fails++;
      $display("FAIL %s done_wait: no done within %0d cycles, expected at %0d", name, budget, lat + 1);
    end
    tests++;
    if (done_cyc != lat + 1) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, lat + 1);
    end
    tests++;
    if ({bus.converged, bus.timeout_error} !== {conv, tmo}) begin
      fails++;
      $display("FAIL %s status conv/tmo: got %b%b expected %b%b", name,
               bus.converged, bus.timeout_error, conv, tmo);
    end
    tests++;
    if (bus.iteration_count !== ITER_W'(iters)) begin
      fails++; $display("FAIL %s iteration_count: got %0d expected %0d", name, bus.iteration_count, iters);
    end
    tests++;
    if (n_rs != iters + int'(tmo) || n_sl != iters) begin
      fails++;
      $display("FAIL %s pulse_counts: got rows=%0d sums=%0d expected rows=%0d sums=%0d",
               name, n_rs, n_sl, iters + int'(tmo), iters);
    end
    step();
    bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.converged, bus.timeout_error, bus.iteration_count}
        !== {2'b00, conv, tmo, ITER_W'(iters)} || n_done != 1) begin
      fails++;
      $display("FAIL %s idle_hold: got busy=%b done=%b conv=%b tmo=%b iter=%0d dones=%0d expected 0 0 %b %b %0d 1",
               name, bus.busy, bus.done, bus.converged, bus.timeout_error, bus.iteration_count,
               n_done, conv, tmo, iters);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tests++;
    if (out_vec() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_convergence();
    stray_en = 0;
    set_delays(2, 2);
    conv_iter = 2;
    run_decode("convergence", 4, 0);
  endtask

  task automatic test_iter_limit();
    stray_en = 1;
    set_delays(1, 6);
    conv_iter = 0;
    run_decode("limit3", 3, 0);
    set_delays(1, 4);
    run_decode("limit0", 0, 0);
    set_delays(1, 3);
    conv_iter = $urandom_range(5, 1);
    run_decode("random_limit", $urandom_range(15, 1), 0);
  endtask

  task automatic test_staggered();
    stray_en = 1;
    set_delays(1, 5);
    for (int it = 0; it < 16; it++) begin
      rd[it][0] = 1; rd[it][1] = 5; rd[it][2] = 9;
    end
    conv_iter = 0;
    run_decode("staggered", 2, 0);
  endtask

  task automatic test_watchdog();
    stray_en = 1;
    set_delays(1, 1);
    cd[0][5] = 0;
    conv_iter = 0;
    run_decode("col_timeout", 2, 0);
    set_delays(1, 2);
    rd[0][0] = 3; rd[0][1] = T; rd[0][2] = 1;
    conv_iter = 1;
    run_decode("expiry_tie", 1, 0);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    stray_en = 1;
    set_delays(1, 4);
    conv_iter = 0;
    tb_clear();
    bus.max_iterations = ITER_W'(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (!(sum_seen == 1 && col_act && col_cnt >= 1) && guard < 200) begin
      step(); guard++;
    end
    tests++;
    if (guard >= 200) begin
      fails++; $display("FAIL reset_mid reach_col_wait: got no COL_WAIT in iteration 2 within %0d cycles", guard);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (out_vec() !== '0) begin
      fails++; $display("FAIL reset_mid outputs: got %h expected 0", out_vec());
    end
    n_done = 0;
    repeat (5) step();
    tests++;
    if (n_done != 0) begin
      fails++; $display("FAIL reset_mid done_pulses: got %0d expected 0", n_done);
    end
    set_delays(1, 3);
    run_decode("after_reset", 2, 0);
  endtask

  task automatic test_handshake();
    int lat, iters, p, expect_n, guard;
    bit conv, tmo;
    stray_en = 0;
    set_delays(1, 1);
    conv_iter = 1;
    model(1, lat, iters, conv, tmo);
    p = lat + 1;
    expect_n = (20 + p - 1) / p;
    tb_clear();
    bus.max_iterations = ITER_W'(1);
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 20) bus.start = 1'b0;
    end
    guard = 0;
    while (bus.busy && guard < 100) begin step(); guard++; end
    repeat (3) step();
    tests++;
    if (n_done != expect_n) begin
      fails++; $display("FAIL held_start decodes: got %0d expected %0d", n_done, expect_n);
    end
    stray_en = 1;
    set_delays(1, 4);
    conv_iter = 0;
    run_decode("start_while_busy", 3, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.max_iterations = '0;
    bus.row_done = '0;
    bus.col_done = '0;
    bus.syndrome_zero = 1'b0;
    stray_en = 0;
    conv_iter = 0;
    tb_clear();
    test_reset();
    test_convergence();
    test_iter_limit();
    test_staggered();
    test_watchdog();
    test_reset_mid();
    test_handshake();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
